ram_dp_clr: RTL and testbench

Parametrised simple-dual-port storage array for the FIFO datapath. It extends the plain write/async-read memory with:
- a registered read port with a valid flag
- byte-lane write enables and write-first collision forwarding
- a hardware clear sequencer that zeroes every location after reset or on request

It sits between the FIFO pointer logic and the read-side output register. It replaces the combinational-read memory wherever timing closure needs a registered read.

---
 rtl/ram_pkg.sv | 28 ++
 rtl/ram_clr_seq.sv | 61 ++++++
 rtl/ram_dp_clr.sv | 114 +++++++++++
 tb/tb_ram_dp_clr.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the clearable dual-port RAM.
// Build option: RAM_OUTREG_EN adds a second read output stage.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int LANE_DEF = 8;
  localparam int MAXW     = 256;

  function automatic logic [MAXW-1:0] lane_merge(
    input logic [MAXW-1:0] old_w,
    input logic [MAXW-1:0] new_w,
    input logic [MAXW-1:0] be,
    input int              lane
  );
    logic [MAXW-1:0] r;
    r = old_w;
    for (int b = 0; b < MAXW; b++) begin
      if (be[8'(b / lane)])
        r[8'(b)] = new_w[8'(b)];
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: walks every address writing zero, then
// holds RUN until a clear request restarts the walk.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
)(
  input  logic          wclk,
  input  logic          wrst_n,
  input  logic          clr_req,
  output logic          ready,
  output logic          cwen,
  output logic [AW-1:0] caddr,
  output logic          enter_clr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        st, st_n;
  logic [AW-1:0] cnt, cnt_n;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      st  <= CLEAR;
      cnt <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
    end
  end

  always_comb begin
    st_n      = st;
    cnt_n     = cnt;
    cwen      = 1'b0;
    caddr     = cnt;
    enter_clr = 1'b0;
    unique case (st)
      CLEAR: begin
        cwen = 1'b1;
        if (cnt == LAST) begin
          st_n  = RUN;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RUN: begin
        if (clr_req) begin
          st_n      = CLEAR;
          cnt_n     = '0;
          enter_clr = 1'b1;
        end
      end
    endcase
  end

  assign ready = (st == RUN);

endmodule

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM, byte-lane writes, registered write-first
// read, hardware clear. Build option: RAM_OUTREG_EN.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LANE  = LANE_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int NL = WIDTH / LANE
)(
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             wen,
  input  logic             full,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NL-1:0]    wbe,
  input  logic             ren,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  input  logic             clr_req,
  output logic             ready
);

  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

  logic          cwen;
  logic [AW-1:0] caddr;
  logic          enter_clr;

  ram_clr_seq #(.DEPTH(DEPTH)) u_seq (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .clr_req   (clr_req),
    .ready     (ready),
    .cwen      (cwen),
    .caddr     (caddr),
    .enter_clr (enter_clr)
  );

  function automatic logic [WIDTH-1:0] merge(
    input logic [WIDTH-1:0] o,
    input logic [WIDTH-1:0] n,
    input logic [NL-1:0]    be
  );
    logic [MAXW-1:0] r;
    r = lane_merge(MAXW'(o), MAXW'(n), MAXW'(be), LANE);
    return r[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  logic             we, re, wr_ok, rd_ok, hit;
  logic [WIDTH-1:0] wold, wnew, rword, rfwd;

  assign we    = wen & ~full & ready;
  assign re    = ren & ready;
  assign wr_ok = {1'b0, waddr} < LIM;
  assign rd_ok = {1'b0, raddr} < LIM;
  assign hit   = we & wr_ok & (waddr == raddr);

  always_comb begin
    wold  = wr_ok ? mem[waddr] : '0;
    rword = rd_ok ? mem[raddr] : '0;
    wnew  = merge(wold, wdata, wbe);
    rfwd  = hit ? wnew : rword;
  end

  // Storage is deliberately unreset; the clear walk initialises it.
  always_ff @(posedge wclk) begin
    if (cwen)
      mem[caddr] <= '0;
    else if (we && wr_ok)
      mem[waddr] <= wnew;
  end

  logic [WIDTH-1:0] rdata1;
  logic             rvalid1;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rdata1  <= '0;
      rvalid1 <= 1'b0;
    end else begin
      if (re)
        rdata1 <= rfwd;
      rvalid1 <= re & ~enter_clr;
    end
  end

`ifdef RAM_OUTREG_EN
  logic [WIDTH-1:0] rdata2;
  logic             rvalid2;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rdata2  <= '0;
      rvalid2 <= 1'b0;
    end else begin
      rdata2  <= rdata1;
      rvalid2 <= rvalid1 & ~enter_clr;
    end
  end

  assign rdata  = rdata2;
  assign rvalid = rvalid2;
`else
  assign rdata  = rdata1;
  assign rvalid = rvalid1;
`endif

endmodule

// File: tb/tb_ram_dp_clr.sv
// Scoreboard bench for ram_dp_clr: DEPTH=16 and DEPTH=12 instances,
// WIDTH=16, two byte lanes.
module tb_ram_dp_clr;

`ifdef RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic wclk = 1'b0;
  always #5 wclk = ~wclk;

  logic        wrst_n;
  logic        wen, full, ren, clr_req;
  logic [3:0]  waddr, raddr;
  logic [15:0] wdata;
  logic [1:0]  wbe;
  logic [15:0] rdata;
  logic        rvalid, ready;

  logic        b_wen, b_full, b_ren, b_clr;
  logic [3:0]  b_waddr, b_raddr;
  logic [15:0] b_wdata;
  logic [1:0]  b_wbe;
  logic [15:0] b_rdata;
  logic        b_rvalid, b_ready;

  ram_dp_clr #(.WIDTH(16), .DEPTH(16), .LANE(8)) dut16 (
    .wclk(wclk), .wrst_n(wrst_n), .wen(wen), .full(full),
    .waddr(waddr), .wdata(wdata), .wbe(wbe), .ren(ren),
    .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
    .clr_req(clr_req), .ready(ready)
  );

  ram_dp_clr #(.WIDTH(16), .DEPTH(12), .LANE(8)) dut12 (
    .wclk(wclk), .wrst_n(wrst_n), .wen(b_wen), .full(b_full),
    .waddr(b_waddr), .wdata(b_wdata), .wbe(b_wbe), .ren(b_ren),
    .raddr(b_raddr), .rdata(b_rdata), .rvalid(b_rvalid),
    .clr_req(b_clr), .ready(b_ready)
  );

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;

  exp_t q16[$];
  exp_t q12[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge wclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge wclk) begin
    if (wrst_n && rvalid) begin
      exp_t e;
      if (q16.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd16_spurious: got rvalid=1 data %h want rvalid=0", rdata);
      end else begin
        e = q16.pop_front();
        chk("rd16_data", rdata, e.d);
        chk("rd16_cycle", cyc, e.c);
      end
    end
  end

  always @(negedge wclk) begin
    if (wrst_n && b_rvalid) begin
      exp_t e;
      if (q12.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd12_spurious: got rvalid=1 data %h want rvalid=0", b_rdata);
      end else begin
        e = q12.pop_front();
        chk("rd12_data", b_rdata, e.d);
        chk("rd12_cycle", cyc, e.c);
      end
    end
  end

  task automatic op16(input logic w, input logic [3:0] wa,
                      input logic [15:0] wd, input logic [1:0] be,
                      input logic f, input logic r,
                      input logic [3:0] ra, input logic [15:0] ed,
                      input logic c);
    wen = w; waddr = wa; wdata = wd; wbe = be; full = f;
    ren = r; raddr = ra; clr_req = c;
    if (r) q16.push_back('{ed, cyc + LAT});
    @(negedge wclk);
    wen = 1'b0; ren = 1'b0; full = 1'b0; clr_req = 1'b0;
  endtask

  task automatic wr16(input logic [3:0] a, input logic [15:0] d,
                      input logic [1:0] be);
    op16(1'b1, a, d, be, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
  endtask

  task automatic rd16(input logic [3:0] a, input logic [15:0] e);
    op16(1'b0, 4'd0, 16'd0, 2'b00, 1'b0, 1'b1, a, e, 1'b0);
  endtask

  task automatic op12(input logic w, input logic [3:0] wa,
                      input logic [15:0] wd, input logic r,
                      input logic [3:0] ra, input logic [15:0] ed);
    b_wen = w; b_waddr = wa; b_wdata = wd; b_wbe = 2'b11;
    b_ren = r; b_raddr = ra;
    if (r) q12.push_back('{ed, cyc + LAT});
    @(negedge wclk);
    b_wen = 1'b0; b_ren = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 64) begin
      @(negedge wclk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int n;
    wrst_n = 1'b0;
    wen = 0; full = 0; ren = 0; clr_req = 0;
    waddr = 0; raddr = 0; wdata = 0; wbe = 0;
    b_wen = 0; b_full = 0; b_ren = 0; b_clr = 0;
    b_waddr = 0; b_raddr = 0; b_wdata = 0; b_wbe = 0;
    repeat (3) @(negedge wclk);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_ready12", b_ready, 1'b0);
    wrst_n = 1'b1;
    wait_ready(n);
    chk("ready_edges", n, 16);
    chk("ready12_up", b_ready, 1'b1);

    for (int a = 0; a < 16; a++) rd16(4'(a), 16'h0000);

    wr16(4'd3, 16'hABCD, 2'b11);
    wr16(4'd3, 16'h1234, 2'b01);
    rd16(4'd3, 16'hAB34);
    wr16(4'd3, 16'hFFFF, 2'b00);
    rd16(4'd3, 16'hAB34);

    wr16(4'd7, 16'h0011, 2'b11);
    op16(1'b1, 4'd7, 16'h5A5A, 2'b10, 1'b0, 1'b1, 4'd7, 16'h5A11, 1'b0);
    rd16(4'd7, 16'h5A11);

    op16(1'b1, 4'd5, 16'hFFFF, 2'b11, 1'b1, 1'b1, 4'd5, 16'h0000, 1'b0);
    rd16(4'd5, 16'h0000);
    op16(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 1'b1, 4'd3, 16'hAB34, 1'b0);
    repeat (3) @(negedge wclk);

    op16(1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
    chk("clr_ready_low", ready, 1'b0);
    ren = 1'b1;
    raddr = 4'd3;
    repeat (8) @(negedge wclk);
    chk("clr_ready_mid", ready, 1'b0);
    ren = 1'b0;
    wrst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 1'b0);
    chk("mid_rst_rvalid", rvalid, 1'b0);
    @(negedge wclk);
    wrst_n = 1'b1;
    wait_ready(n);
    chk("reclear_edges", n, 16);
    for (int a = 0; a < 16; a++) rd16(4'(a), 16'h0000);

    chk("ready12_run", b_ready, 1'b1);
    op12(1'b1, 4'd13, 16'hBEEF, 1'b0, 4'd0, 16'h0000);
    op12(1'b1, 4'd11, 16'h1111, 1'b0, 4'd0, 16'h0000);
    op12(1'b0, 4'd0, 16'h0000, 1'b1, 4'd13, 16'h0000);
    op12(1'b0, 4'd0, 16'h0000, 1'b1, 4'd11, 16'h1111);
    op12(1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'h0000);
    op12(1'b1, 4'd13, 16'hCAFE, 1'b1, 4'd13, 16'h0000);

    repeat (4) @(negedge wclk);
    chk("q16_drained", q16.size(), 0);
    chk("q12_drained", q12.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
